// File: rtl/dm_pkg.sv
// Debug-module shared types: system bus access state machine and sberror codes.
package dm;

    typedef enum logic [2:0] {
        Idle,
        Read,
        Write,
        WaitRead,
        WaitWrite
    } sba_state_e;

    localparam logic [2:0] SbErrNone    = 3'd0;
    localparam logic [2:0] SbErrTimeout = 3'd1;
    localparam logic [2:0] SbErrBadAddr = 3'd2;
    localparam logic [2:0] SbErrAlign   = 3'd3;
    localparam logic [2:0] SbErrSize    = 3'd4;
    localparam logic [2:0] SbErrOther   = 3'd7;

endpackage

// File: rtl/dm_sba_ctrl.sv
// System bus access controller: turns sbcs/sbaddress/sbdata triggers into single
// bus transactions and reports completion, read data and sberror back to the CSRs.
module dm_sba_ctrl
    import dm::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sbreadondata_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbdata_write_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic                  sbaddress_update_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic [2:0]            sberror_o,
    output logic                  sberror_valid_o,
    output logic                  req_o,
    output logic [BusWidth-1:0]   add_o,
    output logic                  we_o,
    output logic [BusWidth-1:0]   wdata_o,
    output logic [BusWidth/8-1:0] be_o,
    input  logic                  gnt_i,
    input  logic                  r_valid_i,
    input  logic                  r_err_i,
    input  logic [BusWidth-1:0]   r_rdata_i
);

    localparam int NumBytes = BusWidth / 8;
    localparam int OffW     = $clog2(NumBytes);

    function automatic logic [NumBytes-1:0] byte_enable(input logic [2:0] access,
                                                        input logic [OffW-1:0] off);
        logic [NumBytes-1:0] be;
        int lo;
        int hi;
        lo = int'(off);
        hi = lo + (1 << access);
        be = '0;
        for (int i = 0; i < NumBytes; i++) be[i] = (i >= lo) && (i < hi);
        return be;
    endfunction

    // Narrow writes copy the low bytes into every lane so any byte offset sees the data.
    function automatic logic [BusWidth-1:0] replicate(input logic [BusWidth-1:0] data,
                                                      input logic [2:0] access);
        logic [BusWidth-1:0] res;
        int n;
        n = 1 << access;
        res = '0;
        for (int i = 0; i < NumBytes; i++) res[8*i +: 8] = data[8*(i % n) +: 8];
        return res;
    endfunction

    function automatic logic [BusWidth-1:0] align_rdata(input logic [BusWidth-1:0] data,
                                                        input logic [2:0] access,
                                                        input logic [OffW-1:0] off);
        logic [BusWidth-1:0] res;
        int n;
        n = 1 << access;
        res = data >> {off, 3'b000};
        for (int i = 0; i < NumBytes; i++) if (i >= n) res[8*i +: 8] = 8'h00;
        return res;
    endfunction

    sba_state_e      state_q;
    logic            trig_write;
    logic            trig_read;
    logic            trigger;
    logic            size_err;
    logic            align_err;
    logic            start;
    logic            resp;
    logic [OffW-1:0] offset;

    assign offset     = sbaddress_i[OffW-1:0];
    assign trig_write = dmactive_i && sbdata_write_valid_i;
    assign trig_read  = dmactive_i && ((sbaddress_write_valid_i && sbreadonaddr_i) ||
                                       (sbdata_read_valid_i && sbreadondata_i));
    assign trigger    = (state_q == Idle) && (trig_write || trig_read);
    assign size_err   = (8 << sbaccess_i) > BusWidth;
    assign start      = trigger && !size_err && !align_err;
    assign resp       = r_valid_i && ((state_q == WaitRead) || (state_q == WaitWrite));

    always_comb begin
        align_err = 1'b0;
        for (int i = 0; i < OffW; i++) begin
            if ((i < int'(sbaccess_i)) && sbaddress_i[i]) align_err = 1'b1;
        end
    end

    assign sbaddress_o        = sbaddress_i + (BusWidth'(1) << sbaccess_i);
    assign sbbusy_o           = (state_q != Idle);
    assign sbdata_valid_o     = resp && (state_q == WaitRead) && !r_err_i;
    assign sbdata_o           = sbdata_valid_o ? align_rdata(r_rdata_i, sbaccess_i, offset) : '0;
    assign sbaddress_update_o = resp && sbautoincrement_i && !r_err_i;
    assign sberror_valid_o    = (trigger && (size_err || align_err)) || (resp && r_err_i);

    // Size beats alignment; a trigger error and a bus error can never coincide.
    always_comb begin
        sberror_o = SbErrNone;
        if (trigger && size_err)       sberror_o = SbErrSize;
        else if (trigger && align_err) sberror_o = SbErrAlign;
        else if (resp && r_err_i)      sberror_o = SbErrBadAddr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            req_o   <= 1'b0;
            we_o    <= 1'b0;
            add_o   <= '0;
            wdata_o <= '0;
            be_o    <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (start) begin
                        state_q <= trig_write ? Write : Read;
                        req_o   <= 1'b1;
                        we_o    <= trig_write;
                        add_o   <= sbaddress_i;
                        wdata_o <= replicate(sbdata_i, sbaccess_i);
                        be_o    <= byte_enable(sbaccess_i, offset);
                    end
                end
                Read, Write: begin
                    if (gnt_i) begin
                        state_q <= (state_q == Read) ? WaitRead : WaitWrite;
                        req_o   <= 1'b0;
                        we_o    <= 1'b0;
                        add_o   <= '0;
                        wdata_o <= '0;
                        be_o    <= '0;
                    end
                end
                WaitRead, WaitWrite: begin
                    if (r_valid_i) state_q <= Idle;
                end
                default: state_q <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Self-checking bench for dm_sba_ctrl: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dm_sba_ctrl;

    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dmactive = 1'b0;
    logic [BW-1:0] sbaddress = '0;
    logic          sbaddress_wv = 1'b0;
    logic          readonaddr = 1'b0;
    logic          autoinc = 1'b0;
    logic [2:0]    access = 3'd0;
    logic          readondata = 1'b0;
    logic [BW-1:0] sbdata = '0;
    logic          sbdata_rv = 1'b0;
    logic          sbdata_wv = 1'b0;
    logic          gnt = 1'b0;
    logic          r_valid = 1'b0;
    logic          r_err = 1'b0;
    logic [BW-1:0] r_rdata = '0;

    logic [BW-1:0] sbaddress_o;
    logic          sbaddress_update_o;
    logic [BW-1:0] sbdata_o;
    logic          sbdata_valid_o;
    logic          sbbusy_o;
    logic [2:0]    sberror_o;
    logic          sberror_valid_o;
    logic          req_o;
    logic [BW-1:0] add_o;
    logic          we_o;
    logic [BW-1:0] wdata_o;
    logic [3:0]    be_o;

    int checks = 0;
    int failures = 0;

    dm_sba_ctrl #(.BusWidth(BW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
        .sbaddress_i(sbaddress), .sbaddress_write_valid_i(sbaddress_wv),
        .sbreadonaddr_i(readonaddr), .sbautoincrement_i(autoinc),
        .sbaccess_i(access), .sbreadondata_i(readondata), .sbdata_i(sbdata),
        .sbdata_read_valid_i(sbdata_rv), .sbdata_write_valid_i(sbdata_wv),
        .sbaddress_o(sbaddress_o), .sbaddress_update_o(sbaddress_update_o),
        .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
        .sberror_o(sberror_o), .sberror_valid_o(sberror_valid_o),
        .req_o(req_o), .add_o(add_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
        .gnt_i(gnt), .r_valid_i(r_valid), .r_err_i(r_err), .r_rdata_i(r_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding access, recorded at its start.
    bit          m_busy = 1'b0;
    bit          m_granted = 1'b0;
    bit          m_write = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [2:0]  m_acc = '0;
    bit          trig_w, trig_r, trig, size_bad, align_bad, resp, e_req;
    bit          e_err_valid, e_data_valid, e_update;
    logic [2:0]  e_err;
    logic [63:0] e_data;
    logic [31:0] e_be_wide;
    logic [31:0] e_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_granted = 1'b0;
        end
        trig_w    = dmactive && sbdata_wv;
        trig_r    = dmactive && ((sbaddress_wv && readonaddr) || (sbdata_rv && readondata));
        trig      = !m_busy && (trig_w || trig_r);
        size_bad  = (8 << access) > BW;
        align_bad = (sbaddress % (32'd1 << access)) != 0;
        resp      = m_busy && m_granted && r_valid;
        e_req     = m_busy && !m_granted;
        e_err_valid  = (trig && (size_bad || align_bad)) || (resp && r_err);
        e_err        = trig ? (size_bad ? 3'd4 : 3'd3) : 3'd2;
        e_data_valid = resp && !m_write && !r_err;
        e_data       = (64'(r_rdata) >> (8 * (m_addr % 4))) & ((64'd1 << (8 << m_acc)) - 64'd1);
        e_update     = resp && autoinc && !r_err;
        e_be_wide    = ((32'd1 << (32'd1 << m_acc)) - 32'd1) << (m_addr % 4);
        case (m_acc)
            3'd0:    e_wdata = {4{m_data[7:0]}};
            3'd1:    e_wdata = {2{m_data[15:0]}};
            default: e_wdata = m_data;
        endcase

        check_output("m_busy", 64'(sbbusy_o), 64'(m_busy));
        check_output("m_req", 64'(req_o), 64'(e_req));
        check_output("m_sbaddress_o", 64'(sbaddress_o), 64'(sbaddress + (32'd1 << access)));
        check_output("m_data_valid", 64'(sbdata_valid_o), 64'(e_data_valid));
        check_output("m_update", 64'(sbaddress_update_o), 64'(e_update));
        check_output("m_err_valid", 64'(sberror_valid_o), 64'(e_err_valid));
        if (e_err_valid) check_output("m_err", 64'(sberror_o), 64'(e_err));
        if (e_data_valid) check_output("m_sbdata", 64'(sbdata_o), e_data);
        if (e_req) begin
            check_output("m_we", 64'(we_o), 64'(m_write));
            check_output("m_add", 64'(add_o), 64'(m_addr));
            check_output("m_be", 64'(be_o), 64'(e_be_wide[3:0]));
            if (m_write) check_output("m_wdata", 64'(wdata_o), 64'(e_wdata));
        end

        if (rst_n) begin
            if (trig && !size_bad && !align_bad) begin
                m_busy    = 1'b1;
                m_granted = 1'b0;
                m_write   = trig_w;
                m_addr    = sbaddress;
                m_data    = sbdata;
                m_acc     = access;
            end else if (m_busy && !m_granted && gnt) begin
                m_granted = 1'b1;
            end else if (resp) begin
                m_busy = 1'b0;
            end
        end
    end

    // Values captured by the bus responder for the directed checks.
    int          cap_req_cycles;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic        cap_dv, cap_upd, cap_ev, cap_busy_after;
    logic [31:0] cap_data, cap_addr_o;
    logic [2:0]  cap_err;

    task automatic apply_stimulus(input int gnt_delay, input int resp_delay,
                                  input logic err, input logic [31:0] rdata);
        int waited = 0;
        while (!req_o && waited < 20) begin
            tick();
            waited++;
        end
        if (!req_o) begin
            check_output("req_timeout", 64'(req_o), 64'd1);
            return;
        end
        cap_be = be_o;
        cap_we = we_o;
        cap_wdata = wdata_o;
        cap_req_cycles = 1;
        repeat (gnt_delay) begin
            tick();
            if (req_o) cap_req_cycles++;
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        repeat (resp_delay) tick();
        r_valid = 1'b1;
        r_err = err;
        r_rdata = rdata;
        @(negedge clk);
        cap_dv = sbdata_valid_o;
        cap_data = sbdata_o;
        cap_upd = sbaddress_update_o;
        cap_addr_o = sbaddress_o;
        cap_ev = sberror_valid_o;
        cap_err = sberror_o;
        tick();
        r_valid = 1'b0;
        r_err = 1'b0;
        r_rdata = '0;
        cap_busy_after = sbbusy_o;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            tick();
            if (req_o || sbbusy_o) seen++;
        end
        check_output(name, 64'(seen), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_output("reset_busy", 64'(sbbusy_o), 64'd0);
        check_output("reset_req", 64'(req_o), 64'd0);
        check_output("reset_be", 64'(be_o), 64'd0);
        check_output("reset_err_valid", 64'(sberror_valid_o), 64'd0);
        tick();
        rst_n = 1'b1;
        dmactive = 1'b1;
        tick();

        // Word write with autoincrement, grant held off two cycles.
        sbaddress = 32'h1000; access = 3'd2; sbdata = 32'hDEADBEEF; autoinc = 1'b1;
        sbdata_wv = 1'b1;
        tick();
        sbdata_wv = 1'b0;
        apply_stimulus(2, 1, 1'b0, 32'h0);
        check_output("wr_req_cycles", 64'(cap_req_cycles), 64'd3);
        check_output("wr_be", 64'(cap_be), 64'hF);
        check_output("wr_we", 64'(cap_we), 64'd1);
        check_output("wr_wdata", 64'(cap_wdata), 64'hDEADBEEF);
        check_output("wr_update", 64'(cap_upd), 64'd1);
        check_output("wr_next_addr", 64'(cap_addr_o), 64'h1004);
        check_output("wr_no_data_valid", 64'(cap_dv), 64'd0);
        check_output("wr_busy_after", 64'(cap_busy_after), 64'd0);

        // Byte read on the top lane, started by an address write.
        sbaddress = 32'h1003; access = 3'd0; autoinc = 1'b0; readonaddr = 1'b1;
        sbaddress_wv = 1'b1;
        tick();
        sbaddress_wv = 1'b0;
        apply_stimulus(0, 0, 1'b0, 32'hAB000000);
        check_output("rdb_be", 64'(cap_be), 64'h8);
        check_output("rdb_we", 64'(cap_we), 64'd0);
        check_output("rdb_valid", 64'(cap_dv), 64'd1);
        check_output("rdb_data", 64'(cap_data), 64'h000000AB);
        check_output("rdb_no_update", 64'(cap_upd), 64'd0);
        @(negedge clk);
        check_output("rdb_valid_one_cycle", 64'(sbdata_valid_o), 64'd0);

        // Misaligned halfword read.
        tick();
        sbaddress = 32'h1001; access = 3'd1;
        sbaddress_wv = 1'b1;
        @(negedge clk);
        check_output("align_err_valid", 64'(sberror_valid_o), 64'd1);
        check_output("align_err_code", 64'(sberror_o), 64'd3);
        tick();
        sbaddress_wv = 1'b0;
        expect_quiet("align_no_activity", 4);

        // Doubleword on a 32-bit bus.
        sbaddress = 32'h1000; access = 3'd3;
        sbdata_wv = 1'b1;
        @(negedge clk);
        check_output("size_err_valid", 64'(sberror_valid_o), 64'd1);
        check_output("size_err_code", 64'(sberror_o), 64'd4);
        tick();
        sbdata_wv = 1'b0;
        expect_quiet("size_no_activity", 4);

        // Write and read-on-address in the same cycle: the write wins.
        sbaddress = 32'h2000; access = 3'd2; sbdata = 32'h12345678;
        sbdata_wv = 1'b1; sbaddress_wv = 1'b1;
        tick();
        sbdata_wv = 1'b0; sbaddress_wv = 1'b0;
        apply_stimulus(1, 1, 1'b0, 32'h0);
        check_output("dual_we", 64'(cap_we), 64'd1);
        check_output("dual_wdata", 64'(cap_wdata), 64'h12345678);
        expect_quiet("dual_single_txn", 4);

        // Read-on-data with a bus error and a stray trigger while busy.
        readonaddr = 1'b0; readondata = 1'b1; autoinc = 1'b1;
        sbaddress = 32'h3000; access = 3'd2;
        sbdata_rv = 1'b1;
        tick();
        sbdata_rv = 1'b0;
        sbdata_wv = 1'b1;
        tick();
        sbdata_wv = 1'b0;
        apply_stimulus(1, 0, 1'b1, 32'hFFFFFFFF);
        check_output("rerr_we", 64'(cap_we), 64'd0);
        check_output("rerr_err_valid", 64'(cap_ev), 64'd1);
        check_output("rerr_code", 64'(cap_err), 64'd2);
        check_output("rerr_no_data", 64'(cap_dv), 64'd0);
        check_output("rerr_no_update", 64'(cap_upd), 64'd0);
        expect_quiet("rerr_busy_trigger_ignored", 4);

        // Trigger while the debug module is inactive.
        dmactive = 1'b0;
        sbdata_wv = 1'b1;
        @(negedge clk);
        check_output("inactive_no_err", 64'(sberror_valid_o), 64'd0);
        tick();
        sbdata_wv = 1'b0;
        dmactive = 1'b1;
        expect_quiet("inactive_no_txn", 3);

        // Reset while waiting for read data.
        readondata = 1'b0; readonaddr = 1'b1;
        sbaddress = 32'h4000; access = 3'd2;
        sbaddress_wv = 1'b1;
        tick();
        sbaddress_wv = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check_output("rst_busy_before", 64'(sbbusy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", 64'(sbbusy_o), 64'd0);
        check_output("rst_req", 64'(req_o), 64'd0);
        check_output("rst_add", 64'(add_o), 64'd0);
        check_output("rst_be", 64'(be_o), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_output("rst_idle_after", 64'(sbbusy_o), 64'd0);
        expect_quiet("rst_quiet_after", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_sba_ctrl.md
# dm_sba_ctrl

System Bus Access (SBA) controller for the RISC-V debug module (v0.13). It sits between the debug-module CSR file (`sbcs`, `sbaddress0/1`, `sbdata0/1`) and a single system-bus master port. It turns CSR-side triggers into one bus transaction at a time, using the shared `sba_state_e` state machine. It also generates byte enables, aligns read data, autoincrements the address, and reports `sberror` codes back to the CSR file.

## Interface
Parameters:
- `BusWidth`, default 32: system-bus address and data width; legal values are 32 or 64.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `dmactive_i`  in  1  debug module active; when low, no new transaction may start.
- `sbaddress_i`  in  BusWidth  current `sbaddress` value.
- `sbaddress_write_valid_i`  in  1  single-cycle pulse: debugger wrote `sbaddress0`.
- `sbreadonaddr_i`  in  1  `sbcs.sbreadonaddr`.
- `sbautoincrement_i`  in  1  `sbcs.sbautoincrement`.
- `sbaccess_i`  in  3  `sbcs.sbaccess` size code: 0=8, 1=16, 2=32, 3=64, 4=128 bit.
- `sbreadondata_i`  in  1  `sbcs.sbreadondata`.
- `sbdata_i`  in  BusWidth  `sbdata` write value.
- `sbdata_read_valid_i`  in  1  pulse: debugger read `sbdata0`.
- `sbdata_write_valid_i`  in  1  pulse: debugger wrote `sbdata0`.
- `sbaddress_o`  out  BusWidth  `sbaddress_i + (1<<sbaccess_i)`, combinational.
- `sbaddress_update_o`  out  1  pulse: CSR file loads `sbaddress_o`.
- `sbdata_o`  out  BusWidth  aligned read data.
- `sbdata_valid_o`  out  1  pulse: CSR file loads `sbdata_o`.
- `sbbusy_o`  out  1  a transaction is in progress.
- `sberror_o`  out  3  error code; meaningful only when `sberror_valid_o` is high.
- `sberror_valid_o`  out  1  pulse: CSR file sets `sbcs.sberror`.
- `req_o`  out  1  bus request.
- `add_o`  out  BusWidth  bus address.
- `we_o`  out  1  bus write enable.
- `wdata_o`  out  BusWidth  bus write data.
- `be_o`  out  BusWidth/8  bus byte enables.
- `gnt_i`  in  1  bus grant.
- `r_valid_i`  in  1  bus response valid.
- `r_err_i`  in  1  bus error response; qualified by `r_valid_i`.
- `r_rdata_i`  in  BusWidth  bus read data.

## Operation
- State register type is `sba_state_e` (Idle, Read, Write, WaitRead, WaitWrite). Reset state is Idle.
- Start triggers in Idle require `dmactive_i` high. Priority order:
  1. `sbdata_write_valid_i` starts a Write.
  2. `sbaddress_write_valid_i && sbreadonaddr_i` starts a Read.
  3. `sbdata_read_valid_i && sbreadondata_i` starts a Read.
- Triggers that arrive outside Idle are ignored. The CSR file owns `sbbusyerror`.
- Checks at the trigger cycle, in Idle. On failure there is no bus activity, the state stays Idle, `sberror_valid_o` pulses in that cycle, and no address update occurs:
  - Size check: `(8<<sbaccess_i) > BusWidth` gives `sberror_o=4`.
  - Alignment check: `sbaddress_i` not aligned to the access size gives `sberror_o=3`. The size check takes precedence.
- In Read and Write, `req_o=1`, `add_o=sbaddress_i`, and `we_o=1` only in Write.
  - `wdata_o` = `sbdata_i` replicated across byte lanes.
  - `be_o` = `((1<<(1<<sbaccess_i))-1) << sbaddress_i[log2(BusWidth/8)-1:0]`.
- On `gnt_i`: Read goes to WaitRead, Write goes to WaitWrite.
- In WaitRead or WaitWrite, on `r_valid_i` the state returns to Idle.
  - WaitRead only: `sbdata_valid_o=1` and `sbdata_o = r_rdata_i >> (8*byte offset)`, with upper bits beyond the access size zeroed.
  - `r_err_i` gives `sberror_o=2` and `sberror_valid_o=1`. In WaitRead it also suppresses `sbdata_valid_o`.
  - `sbaddress_update_o = sbautoincrement_i && !r_err_i`.
- `dmactive_i` dropping mid-transaction: the in-flight transaction runs to completion on the bus, because a bus request is never withdrawn. Completion pulses are still generated.

## Timing
- Reset values: state Idle; every output 0, except `sbaddress_o`, which is combinational from its inputs.
- `sbbusy_o = (state != Idle)`. It rises the cycle after the trigger and falls the cycle after `r_valid_i`.
- `req_o` is first asserted the cycle after the trigger.
- `req_o`, `add_o`, `we_o`, `wdata_o` and `be_o` are held stable until the cycle `gnt_i` is high.
- Grant and response are never in the same cycle. A response is accepted only in a Wait state.
- `sbdata_valid_o`, `sbaddress_update_o` and `sberror_valid_o` are combinational in the `r_valid_i` cycle and last exactly one cycle.
- Minimum transaction length, trigger to Idle: 3 cycles.
- The inputs `sbaddress_i`, `sbdata_i`, `sbaccess_i` and `sbautoincrement_i` must stay stable while `sbbusy_o` is high. The CSR file guarantees this.

## Structure
- `sba_state_e` already lives in package `dm`.
- Add these sberror localparams to `dm`: `SbErrNone=0`, `SbErrTimeout=1`, `SbErrBadAddr=2`, `SbErrAlign=3`, `SbErrSize=4`, `SbErrOther=7`.
- Single module; no sub-modules. Byte-enable and alignment logic are local functions.

## Test plan
- BusWidth=32, `sbaccess=2`, write `sbdata0=0xDEADBEEF` at address 0x1000 with gnt delayed 2 cycles:
  - `req_o` is held 3 cycles.
  - `be_o=0xF`, `we_o=1`.
  - Autoincrement on gives `sbaddress_update_o` pulse with `sbaddress_o=0x1004`.
- Byte read at 0x1003 (`sbaccess=0`, readonaddr) with `r_rdata_i=0xAB000000`: `be_o=0x8`, `sbdata_o=0x000000AB`, one-cycle `sbdata_valid_o`.
- Halfword read at 0x1001: `sberror_o=3` pulse, `req_o` never rises, `sbbusy_o` stays 0.
- BusWidth=32, `sbaccess=3`: `sberror_o=4`, no request. Also, when both triggers fire together, the write wins and exactly one transaction occurs.
- Read with `r_err_i=1`: `sberror_o=2`, no `sbdata_valid_o`, no address update. A second trigger issued while busy is ignored.
- Assert `rst_ni` low in WaitRead: all outputs go to 0 immediately and the state is Idle after release.
